// File: rtl/uart_mem_pkg.sv
// Shared constants for the UART memory loader: command/response bytes and FSM state encoding.
package uart_mem_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE       = 4'd0;
    localparam state_t ST_ADDR       = 4'd1;
    localparam state_t ST_LEN        = 4'd2;
    localparam state_t ST_LD_DATA    = 4'd3;
    localparam state_t ST_LD_WRITE   = 4'd4;
    localparam state_t ST_RD_ISSUE   = 4'd5;
    localparam state_t ST_RD_CAPTURE = 4'd6;
    localparam state_t ST_TX_BYTE    = 4'd7;
    localparam state_t ST_TX_WAIT    = 4'd8;
    localparam state_t ST_RESP       = 4'd9;
    localparam state_t ST_RESP_WAIT  = 4'd10;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_LOAD) || (b == CMD_DUMP);
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// UART byte stream plus single-port memory bus seen by uart_mem_loader.
interface uart_mem_loader_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_wr_en;
    logic [WIDTH-1:0]  mem_rdata;
    logic              busy;
    logic              err;

    modport master (
        input  rx_data, rx_valid, tx_done, mem_rdata,
        output tx_data, tx_start, mem_addr, mem_wdata, mem_wr_en, busy, err
    );

    modport slave (
        output rx_data, rx_valid, tx_done, mem_rdata,
        input  tx_data, tx_start, mem_addr, mem_wdata, mem_wr_en, busy, err
    );
endinterface

// File: rtl/byte_word_packer.sv
// WIDTH-bit shift register: bytes enter at the top (little-endian packing) and leave from the bottom.
module byte_word_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             par_load_i,
    input  logic [7:0]       byte_i,
    input  logic [WIDTH-1:0] word_i,
    output logic [WIDTH-1:0] loaded_o,
    output logic [7:0]       next_byte_o,
    output logic             last_o
);
    localparam int BPW = WIDTH / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [WIDTH-1:0] word_q, word_d, shifted_s;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc_s;

    assign shifted_s   = word_q >> 8;
    assign loaded_o    = shifted_s | (WIDTH'(byte_i) << (WIDTH - 8));
    assign next_byte_o = shifted_s[7:0];
    assign last_o      = (cnt_q == CW'(BPW - 1));
    assign cnt_inc_s   = last_o ? {CW{1'b0}} : (cnt_q + CW'(1));

    // next word/count: clear, parallel load, byte load or shift-out
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            word_d = {WIDTH{1'b0}};
            cnt_d  = {CW{1'b0}};
        end else if (par_load_i) begin
            word_d = word_i;
            cnt_d  = {CW{1'b0}};
        end else if (load_i) begin
            word_d = loaded_o;
            cnt_d  = cnt_inc_s;
        end else if (shift_i) begin
            word_d = shifted_s;
            cnt_d  = cnt_inc_s;
        end else begin
            word_d = word_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Command-driven UART <-> memory bridge (LOAD 'L' / DUMP 'D').
// Optional inter-byte timeout enabled by defining UART_MEM_LOADER_TIMEOUT_EN.
module uart_mem_loader
    import uart_mem_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    uart_mem_loader_if.master bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ABYTES = (ADDR_W + 7) / 8;
    localparam int AW8    = ABYTES * 8;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        wcnt_q, wcnt_d;
    logic [1:0]        abyte_q, abyte_d;
    logic              is_load_q, is_load_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q;
    logic              err_q, err_d;
    logic [4:0]        sh_s;
    logic [AW8-1:0]    addr_ins_s;
    logic              timeout_s;
    logic              pk_clr_s, pk_load_s, pk_shift_s, pk_par_s, pk_last_s;
    logic [WIDTH-1:0]  pk_loaded_s;
    logic [7:0]        pk_next_byte_s;

    byte_word_packer #(.WIDTH(WIDTH)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (pk_clr_s),
        .load_i     (pk_load_s),
        .shift_i    (pk_shift_s),
        .par_load_i (pk_par_s),
        .byte_i     (bus.rx_data),
        .word_i     (bus.mem_rdata),
        .loaded_o   (pk_loaded_s),
        .next_byte_o(pk_next_byte_s),
        .last_o     (pk_last_s)
    );

    // the address register is cleared on each command, so address bytes can simply be OR-ed in
    assign sh_s       = {abyte_q, 3'b000};
    assign addr_ins_s = AW8'(addr_q) | (AW8'(bus.rx_data) << sh_s);

`ifdef UART_MEM_LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        waiting_s;

    assign waiting_s = ((state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_LD_DATA))
                       && !bus.rx_valid;
    assign timeout_s = waiting_s && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
    assign tmo_d     = waiting_s ? (tmo_q + 32'd1) : 32'd0;

    // inter-byte idle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_s;
    assign unused_tmo_s = ^(32'(TIMEOUT_CYCLES));
    assign timeout_s    = 1'b0;
`endif

    // FSM next-state and datapath control
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        abyte_d    = abyte_q;
        is_load_d  = is_load_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        err_d      = err_q;
        pk_clr_s   = 1'b0;
        pk_load_s  = 1'b0;
        pk_shift_s = 1'b0;
        pk_par_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && is_cmd(bus.rx_data)) begin
                    is_load_d = (bus.rx_data == CMD_LOAD);
                    addr_d    = {ADDR_W{1'b0}};
                    abyte_d   = 2'd0;
                    err_d     = 1'b0;
                    state_d   = ST_ADDR;
                end else if (bus.rx_valid) begin
                    tx_data_d = RSP_NAK;
                    err_d     = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    addr_d  = addr_ins_s[ADDR_W-1:0];
                    abyte_d = abyte_q + 2'd1;
                    state_d = (abyte_q == 2'(ABYTES - 1)) ? ST_LEN : ST_ADDR;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_LEN: begin
                if (bus.rx_valid) begin
                    wcnt_d   = {1'b0, bus.rx_data} + 9'd1;
                    pk_clr_s = 1'b1;
                    state_d  = is_load_q ? ST_LD_DATA : ST_RD_ISSUE;
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_LD_DATA: begin
                if (bus.rx_valid) begin
                    pk_load_s = 1'b1;
                    if (pk_last_s) begin
                        wdata_d = pk_loaded_s;
                        wr_en_d = 1'b1;
                        state_d = ST_LD_WRITE;
                    end else begin
                        state_d = ST_LD_DATA;
                    end
                end else begin
                    state_d = ST_LD_DATA;
                end
            end
            ST_LD_WRITE: begin
                // mem_addr still shows the word just written; bump it for the next one
                addr_d = addr_q + ADDR_W'(1);
                wcnt_d = wcnt_q - 9'd1;
                if (wcnt_q == 9'd1) begin
                    tx_data_d = RSP_ACK;
                    state_d   = ST_RESP;
                end else if (bus.rx_valid) begin
                    pk_load_s = 1'b1;
                    if (pk_last_s) begin
                        wdata_d = pk_loaded_s;
                        wr_en_d = 1'b1;
                        state_d = ST_LD_WRITE;
                    end else begin
                        state_d = ST_LD_DATA;
                    end
                end else begin
                    state_d = ST_LD_DATA;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                pk_par_s   = 1'b1;
                tx_data_d  = bus.mem_rdata[7:0];
                tx_start_d = 1'b1;
                state_d    = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (bus.tx_done && pk_last_s) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    wcnt_d  = wcnt_q - 9'd1;
                    state_d = (wcnt_q == 9'd1) ? ST_IDLE : ST_RD_ISSUE;
                end else if (bus.tx_done) begin
                    pk_shift_s = 1'b1;
                    tx_data_d  = pk_next_byte_s;
                    tx_start_d = 1'b1;
                    state_d    = ST_TX_BYTE;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            ST_RESP: begin
                tx_start_d = 1'b1;
                state_d    = ST_RESP_WAIT;
            end
            ST_RESP_WAIT: begin
                state_d = bus.tx_done ? ST_IDLE : ST_RESP_WAIT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout_s) begin
            tx_data_d = RSP_NAK;
            err_d     = 1'b1;
            state_d   = ST_RESP;
        end else begin
            err_d = err_d;
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= {ADDR_W{1'b0}};
            wcnt_q     <= 9'd0;
            abyte_q    <= 2'd0;
            is_load_q  <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            wdata_q    <= {WIDTH{1'b0}};
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            abyte_q    <= abyte_d;
            is_load_q  <= is_load_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= (state_d != ST_IDLE);
            err_q      <= err_d;
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr_en = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader with write/transmit scoreboards and a transmitter model.
module tb_uart_mem_loader;

    typedef struct {
        logic [7:0] b;
        int         gap;
    } tx_ent_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_ent_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem [256];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          lat = 0;
    int          idle_cyc = 0;
    tx_ent_t     tx_q [$];
    wr_ent_t     wr_q [$];
    logic [31:0] ld_words [$];
    tx_ent_t     cur;
    wr_ent_t     wexp;

    uart_mem_loader_if #(.WIDTH(32), .ADDR_W(8)) bus ();

    uart_mem_loader #(.WIDTH(32), .DEPTH(256), .TIMEOUT_CYCLES(100)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // transmitter model: checks each tx_start against the scoreboard, answers with tx_done
    initial begin : tx_model
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (!reset) begin
                lat = 0;
            end else if (lat > 0) begin
                chk("tx_restart", 64'(bus.tx_start), 64'd0);
                chk("tx_hold", 64'(bus.tx_data), 64'(cur.b));
                lat--;
                if (lat == 0) begin
                    bus.tx_done = 1'b1;
                    done_cyc = cyc;
                end
            end else if (bus.tx_start) begin
                if (tx_q.size() == 0) begin
                    chk("tx_extra", 64'(bus.tx_data), 64'h100);
                    cur.b = bus.tx_data;
                end else begin
                    cur = tx_q.pop_front();
                    chk("tx_byte", 64'(bus.tx_data), 64'(cur.b));
                    if (cur.gap > 0) chk("tx_gap", 64'(cyc - done_cyc), 64'(cur.gap));
                end
                lat = 3;
            end
        end
    end

    // write monitor against the write scoreboard
    initial begin : wr_mon
        forever begin
            @(negedge clk);
            if (reset && bus.mem_wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_extra", 64'(bus.mem_addr), 64'h100);
                end else begin
                    wexp = wr_q.pop_front();
                    chk("wr_addr", 64'(bus.mem_addr), 64'(wexp.addr));
                    chk("wr_data", 64'(bus.mem_wdata), 64'(wexp.data));
                    chk("wr_cycle", 64'(cyc), 64'(wexp.cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
    endtask

    task automatic end_burst();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic data_words(input logic [7:0] a);
        logic [31:0] w;
        for (int i = 0; i < ld_words.size(); i++) begin
            w = ld_words[i];
            for (int j = 0; j < 4; j++) begin
                drive(w[8*j +: 8]);
                if (j == 3) wr_q.push_back('{8'(int'(a) + i), w, cyc + 1});
            end
        end
        tx_q.push_back('{8'h06, 0});
    endtask

    task automatic do_load(input logic [7:0] a);
        drive(8'h4C);
        drive(a);
        drive(8'(ld_words.size() - 1));
        data_words(a);
        end_burst();
    endtask

    task automatic wait_idle(output int c);
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(bus.busy), 64'd0);
        c = cyc;
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_tx_left"}, 64'(tx_q.size()), 64'd0);
        chk({tag, "_wr_left"}, 64'(wr_q.size()), 64'd0);
    endtask

    initial begin : stim
        reset        = 1'b0;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({bus.tx_data, bus.tx_start, bus.mem_addr, bus.mem_wdata,
                                  bus.mem_wr_en, bus.busy, bus.err}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // LOAD two words at address 0
        ld_words = '{32'h44332211, 32'h88776655};
        do_load(8'h00);
        wait_idle(idle_cyc);
        chk("busy_fall_after_ack", 64'(idle_cyc - done_cyc), 64'd1);
        queues_empty("load0");

        // DUMP them back, byte by byte, LSB first
        tx_q.push_back('{8'h11, 0});
        tx_q.push_back('{8'h22, 1});
        tx_q.push_back('{8'h33, 1});
        tx_q.push_back('{8'h44, 1});
        tx_q.push_back('{8'h55, 3});
        tx_q.push_back('{8'h66, 1});
        tx_q.push_back('{8'h77, 1});
        tx_q.push_back('{8'h88, 1});
        drive(8'h44);
        drive(8'h00);
        drive(8'h01);
        end_burst();
        wait_idle(idle_cyc);
        repeat (10) @(negedge clk);
        queues_empty("dump0");

        // LOAD across the top of memory: 255 then 0
        ld_words = '{32'hA4A3A2A1, 32'hA8A7A6A5};
        do_load(8'hFF);
        wait_idle(idle_cyc);
        queues_empty("wrap");

        // unknown command -> NAK and err
        tx_q.push_back('{8'h15, 0});
        drive(8'h5A);
        end_burst();
        wait_idle(idle_cyc);
        chk("nak_err_set", 64'(bus.err), 64'd1);
        queues_empty("nak");

        // valid command clears err; dump word 0 (written by the wrap load)
        drive(8'h44);
        end_burst();
        chk("err_cleared", 64'(bus.err), 64'd0);
        chk("busy_after_cmd", 64'(bus.busy), 64'd1);
        tx_q.push_back('{8'hA5, 0});
        tx_q.push_back('{8'hA6, 1});
        tx_q.push_back('{8'hA7, 1});
        tx_q.push_back('{8'hA8, 1});
        drive(8'h00);
        drive(8'h00);
        end_burst();
        wait_idle(idle_cyc);
        repeat (10) @(negedge clk);
        queues_empty("dump_wrap");

        // reset mid-word aborts without a write or ACK
        drive(8'h4C);
        drive(8'h00);
        drive(8'h00);
        drive(8'hAA);
        drive(8'hBB);
        end_burst();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_outputs", 64'({bus.tx_data, bus.tx_start, bus.mem_addr, bus.mem_wdata,
                                     bus.mem_wr_en, bus.busy, bus.err}), 64'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("midreset_no_busy", 64'(bus.busy), 64'd0);
        ld_words = '{32'hCAFEF00D};
        do_load(8'h10);
        wait_idle(idle_cyc);
        queues_empty("after_reset");

        // stall after the address byte
`ifdef UART_MEM_LOADER_TIMEOUT_EN
        tx_q.push_back('{8'h15, 0});
        drive(8'h4C);
        drive(8'h00);
        end_burst();
        wait_idle(idle_cyc);
        chk("timeout_err", 64'(bus.err), 64'd1);
        queues_empty("timeout");
`else
        drive(8'h4C);
        drive(8'h00);
        end_burst();
        repeat (150) @(negedge clk);
        chk("stall_busy", 64'(bus.busy), 64'd1);
        chk("stall_no_tx", 64'(tx_q.size()), 64'd0);
        ld_words = '{32'h13579BDF};
        drive(8'h00);
        data_words(8'h00);
        end_burst();
        wait_idle(idle_cyc);
        chk("stall_err", 64'(bus.err), 64'd0);
        queues_empty("stall");
`endif

        repeat (10) @(negedge clk);
        queues_empty("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Command-driven bridge between the UART byte stream (receiver `data_ready`/`data_out`, transmitter `tx_start`/`tx_done`) and one single-port synchronous memory of parametrised width and depth. It packs received bytes into WIDTH-bit words and burst-writes them at an auto-incrementing address (LOAD). It also reads bursts back and serialises them byte by byte to the transmitter (DUMP). It sits between the UART units and a `mem_single`-style memory in board-level test harnesses, replacing the fixed byte-wide, write-only hookup.

## Interface
- `WIDTH`, 32, memory word width; multiple of 8, 8..256.
- `DEPTH`, 256, word count; power of two, 2..65536.
- `TIMEOUT_CYCLES`, 1000000, inter-byte timeout in clk cycles (used only with the macro).
- Derived localparams: `ADDR_W = $clog2(DEPTH)`, `BPW = WIDTH/8`, `ABYTES = ceil(ADDR_W/8)`.

- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_done`.
- `tx_start`  out  1  one-cycle strobe.
- `tx_done`  in  1  one-cycle strobe from the transmitter.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  WIDTH  write data.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_rdata`  in  WIDTH  read data, valid 1 cycle after `mem_addr` is presented.
- `busy`  out  1  high whenever state is not IDLE.
- `err`  out  1  sticky; set on any NAK; cleared by the next valid command byte.

## Operation
- Frame: CMD byte, then ABYTES address bytes (little-endian; bits above ADDR_W ignored), then LEN byte. The word count is LEN+1 (1..256).
- CMD 0x4C ('L') = LOAD. CMD 0x44 ('D') = DUMP. Any other value: transmit NAK 0x15, set `err`, return to IDLE.
- LOAD: receives (LEN+1)*BPW bytes, little-endian within each word (first byte goes to bits [7:0]). Completing a word pulses `mem_wr_en` with `mem_addr` = current address, then address += 1. After the last word it transmits ACK 0x06.
- DUMP: for each word it reads at the current address, captures `mem_rdata`, and transmits BPW bytes LSB first, then address += 1. No ACK follows.
- Address arithmetic is modulo DEPTH: DEPTH-1 wraps to 0. The word counter is 9 bits.
- While transmitting (DUMP or a response), `rx_valid` strobes are ignored and dropped.
- States: IDLE, ADDR, LEN, LD_DATA, LD_WRITE, RD_ISSUE, RD_CAPTURE, TX_BYTE, TX_WAIT, RESP, RESP_WAIT.
  - IDLE→ADDR on a valid CMD.
  - ADDR→LEN after ABYTES bytes.
  - LEN→LD_DATA or RD_ISSUE.
  - LD_DATA→LD_WRITE on the last byte of a word.
  - LD_WRITE→LD_DATA, or RESP when the count is exhausted.
  - RD_ISSUE→RD_CAPTURE→TX_BYTE↔TX_WAIT. After the last byte of a word: RD_ISSUE, or IDLE when done.
  - RESP→RESP_WAIT→IDLE.

## Timing
- Reset values: every output is 0, state is IDLE, `err` is 0, address, counters and the pack/shift register are 0.
- Reset asserted mid-operation aborts immediately. No partial word is written and no ACK is sent.
- LOAD: `mem_wr_en` pulses exactly 1 cycle after the `rx_valid` of a word's final byte.
- DUMP: `mem_addr` is driven in RD_ISSUE, and `mem_rdata` is sampled in RD_CAPTURE (next cycle). `tx_start` for byte 0 fires the cycle after that.
- Each subsequent `tx_start` fires 1 cycle after the previous `tx_done`.
- `tx_start` is never re-asserted before `tx_done`. A `tx_done` arriving outside TX_WAIT/RESP_WAIT is ignored.
- An `rx_valid` coinciding with the final `tx_done` of a dump is dropped.
- Back-to-back `rx_valid` on consecutive cycles must be accepted in IDLE, ADDR, LEN and LD_DATA. LD_WRITE also accepts a byte in the same cycle.

## Configuration
- `UART_MEM_LOADER_TIMEOUT_EN` defined: a counter reloads on each accepted byte while in ADDR, LEN or LD_DATA. When it reaches TIMEOUT_CYCLES without a byte, the block transmits NAK 0x15, sets `err` and returns to IDLE. Words already written remain.
- Macro undefined: no counter; the block waits indefinitely for bytes, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package `uart_mem_pkg`: command/response byte constants (0x4C, 0x44, 0x06, 0x15) and the state enum encoding.
- One sub-module, `byte_word_packer`: a WIDTH-bit shift register with byte counter. It has a load-byte mode (for receive) and a parallel-load/shift-out mode (for transmit), so the byte-lane logic is not duplicated in the FSM.

## Test plan
- Send 4C 00 01 11 22 33 44 55 66 77 88 (WIDTH=32, DEPTH=256) → writes 0x44332211 at address 0 and 0x88776655 at address 1, then tx 06; `busy` falls after the 06 `tx_done`.
- Send 44 00 01 after the above → tx 11 22 33 44 55 66 77 88 in order, each `tx_start` 1 cycle after the prior `tx_done`; no ACK.
- Send 4C FF 01 plus 8 bytes → writes land at addresses 255 and 0 (wrap).
- Send 5A → tx 15, `err`=1; a following valid 44 clears `err`.
- Assert `reset` after 4C 00 00 AA BB → no `mem_wr_en`, no tx, all outputs 0; a new LOAD then works normally.
- With the macro, TIMEOUT_CYCLES=100: send 4C 00 and stall 100 cycles → tx 15, `err`=1, IDLE; without the macro → still in LEN.
